csel_a32: RTL and testbench
===========================

// Module: csel_a32
// PURPOSE
//  32-bit unsigned carry-select adder with a registered result.
//  Computes sum = a + b with carry-in fixed at 0; cout is the carry out of bit 31.
//  Datapath arithmetic block used wherever a fast 32-bit add with one cycle of latency is needed.
//  Internally: a ripple-carry lowest block, then per upper block two precomputed ripples
//  (carry-in 0 and carry-in 1) whose results are selected by the incoming block carry.
// PARAMETERS
//  BLK_W   4   bits per carry-select block; must divide 32 evenly (legal values 2, 4, 8, 16)
// PORTS
//  clk     in   1   rising-edge clock
//  rst_n   in   1   asynchronous, active-low reset
//  a       in   32  addend A, unsigned
//  b       in   32  addend B, unsigned
//  sum     out  32  registered (a + b) mod 2^32
//  cout    out  1   registered carry out of bit 31
// BEHAVIOUR
//  - Reset: rst_n=0 immediately forces sum=32'h0 and cout=0, independent of clk.
//    Outputs hold these values while rst_n=0.
//  - Latency is 1 cycle. On each rising clk with rst_n=1:
//    {cout,sum} <= a + b, using the a and b values present at that edge.
//  - No handshake and no enable. A new add is accepted every cycle and throughput is 1 per clock.
//  - Block 0 (bits BLK_W-1:0): ripple-carry adder with carry-in 0.
//  - Block k>0: two ripple adders over the block bits, one with cin=0 and one with cin=1.
//    The carry out of block k-1 drives a 2:1 mux that selects that block's sum bits and block carry.
//  - The final block carry is cout. Result must equal the plain 33-bit sum {1'b0,a}+{1'b0,b}.
//  - Wrap-around: the sum is taken mod 2^32, and overflow is reported only via cout.
//  - No carry-in port exists; the carry into bit 0 is tied to 0.
//  - Reset release: the first valid result appears on the first rising clk after rst_n rises.
//    Asserting rst_n mid-stream discards any result in flight.
//  - No X-propagation from unused logic: every output bit is driven from a flop.
// TESTING
//  1) a=A0A0FFFF, b=A0BFFFE0 -> after 1 clk: sum=4160FFDF, cout=1
//  2) a=58FFFFF4, b=F4F4FFFF -> sum=4DF4FFF3, cout=1
//     a=FFFF0F3D, b=0F0FFFFF -> sum=0F0F0F3C, cout=1
//     a=DFFFE8CA, b=CFFFF8CA -> sum=AFFFE194, cout=1
//     Apply back-to-back; each result appears exactly one clk after its operands.
//  3) Full carry ripple through every select stage: a=FFFFFFFF, b=00000001 -> sum=00000000, cout=1.
//     Also a=7FFFFFFF, b=00000001 -> sum=80000000, cout=0.
//  4) Zero and identity: a=0, b=0 -> sum=0, cout=0; a=12345678, b=0 -> sum=12345678, cout=0.
//  5) Reset: drive rst_n=0 between clock edges while sum is nonzero.
//     -> sum=0 and cout=0 immediately, before the next edge.
//     -> After rst_n=1, the next clk loads the current a+b.
//  6) Random: 10k random a,b pairs, each with BLK_W=2, 4, 8 and 16.
//     -> every {cout,sum} equals the 33-bit golden sum, one cycle later.

Source files
------------

// File: rtl/csel_a32_if.sv
`default_nettype none
// ============================================================================
// Module  : csel_a32_if
// Purpose : Operand/result bundle for the csel_a32 carry-select adder.
// Rev     : 1.0  initial release
// ============================================================================
interface csel_a32_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] sum;
  logic        cout;

  modport master (output a, b, input sum, cout);
  modport slave  (input a, b, output sum, cout);
endinterface
`default_nettype wire

// File: rtl/csel_a32.sv
`default_nettype none
// ============================================================================
// Module  : csel_a32
// Purpose : 32-bit unsigned carry-select adder with one cycle of registered latency.
// Rev     : 1.0  initial release
// ============================================================================
module csel_a32 #(
  parameter int BLK_W = 4
) (
  input  wire         clk,
  input  wire         rst_n,
  csel_a32_if.slave   bus_if
);

  localparam int NBLK = 32 / BLK_W;

  logic [31:0]   sum_d;
  logic [31:0]   sum_q;
  logic          cout_d;
  logic          cout_q;
  logic [NBLK:1] w_c;

  // Returns {carry_out, sum} of a BLK_W-bit ripple add.
  function automatic logic [BLK_W:0] ripple(input logic [BLK_W-1:0] x,
                                            input logic [BLK_W-1:0] y,
                                            input logic             cin);
    logic             c;
    logic [BLK_W-1:0] s;
    c = cin;
    s = '0;
    for (int i = 0; i < BLK_W; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    if (k == 0) begin : g_rca
      logic [BLK_W:0] w_r;
      assign w_r                = ripple(bus_if.a[BLK_W-1:0], bus_if.b[BLK_W-1:0], 1'b0);
      assign sum_d[BLK_W-1:0]   = w_r[BLK_W-1:0];
      assign w_c[1]             = w_r[BLK_W];
    end else begin : g_sel
      logic [BLK_W:0] w_r0;
      logic [BLK_W:0] w_r1;
      assign w_r0 = ripple(bus_if.a[k*BLK_W +: BLK_W], bus_if.b[k*BLK_W +: BLK_W], 1'b0);
      assign w_r1 = ripple(bus_if.a[k*BLK_W +: BLK_W], bus_if.b[k*BLK_W +: BLK_W], 1'b1);
      // Incoming block carry picks the precomputed result, so the chain is one mux per block.
      assign {w_c[k+1], sum_d[k*BLK_W +: BLK_W]} = w_c[k] ? w_r1 : w_r0;
    end
  end

  assign cout_d = w_c[NBLK];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign bus_if.sum  = sum_q;
  assign bus_if.cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_csel_a32.sv
`default_nettype none
// ============================================================================
// Module  : tb_csel_a32
// Purpose : Self-checking bench for csel_a32 across BLK_W = 2, 4, 8, 16.
// Rev     : 1.0  initial release
// ============================================================================
module tb_csel_a32;

  localparam int NINST = 4;
  localparam int NRAND = 10000;

  logic clk;
  logic rst_n;
  logic [31:0] a_s;
  logic [31:0] b_s;

  int n_checks;
  int n_fail;

  csel_a32_if if2  ();
  csel_a32_if if4  ();
  csel_a32_if if8  ();
  csel_a32_if if16 ();

  assign if2.a  = a_s;  assign if2.b  = b_s;
  assign if4.a  = a_s;  assign if4.b  = b_s;
  assign if8.a  = a_s;  assign if8.b  = b_s;
  assign if16.a = a_s;  assign if16.b = b_s;

  csel_a32 #(.BLK_W(2))  u_dut2  (.clk(clk), .rst_n(rst_n), .bus_if(if2.slave));
  csel_a32 #(.BLK_W(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus_if(if4.slave));
  csel_a32 #(.BLK_W(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus_if(if8.slave));
  csel_a32 #(.BLK_W(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus_if(if16.slave));

  logic [32:0] w_obs [NINST];
  assign w_obs[0] = {if2.cout,  if2.sum};
  assign w_obs[1] = {if4.cout,  if4.sum};
  assign w_obs[2] = {if8.cout,  if8.sum};
  assign w_obs[3] = {if16.cout, if16.sum};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got cout=%0b sum=%08h, expected cout=%0b sum=%08h",
               tag, obs[32], obs[31:0], exp[32], exp[31:0]);
    end
  endtask

  task automatic chk_all(input string tag, input logic [32:0] exp);
    for (int i = 0; i < NINST; i++)
      chk($sformatf("%s/blk%0d", tag, 2 << i), w_obs[i], exp);
  endtask

  // Reference: plain 33-bit arithmetic sum.
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Drive operands between edges, then check one edge later.
  task automatic add_chk(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [32:0] exp);
    @(negedge clk);
    a_s = x;
    b_s = y;
    @(posedge clk);
    #1;
    chk_all(tag, exp);
  endtask

  typedef struct { logic [31:0] a; logic [31:0] b; logic [32:0] e; } vec_t;
  vec_t dir [8];

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    n_checks = 0;
    n_fail   = 0;
    a_s      = 32'h0;
    b_s      = 32'h0;
    rst_n    = 1'b0;

    #1;
    chk_all("reset_state", 33'h0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_hold", 33'h0);
    @(negedge clk);
    rst_n = 1'b1;

    dir[0] = '{32'hA0A0FFFF, 32'hA0BFFFE0, {1'b1, 32'h4160FFDF}};
    dir[1] = '{32'h58FFFFF4, 32'hF4F4FFFF, {1'b1, 32'h4DF4FFF3}};
    dir[2] = '{32'hFFFF0F3D, 32'h0F0FFFFF, {1'b1, 32'h0F0F0F3C}};
    dir[3] = '{32'hDFFFE8CA, 32'hCFFFF8CA, {1'b1, 32'hAFFFE194}};
    dir[4] = '{32'hFFFFFFFF, 32'h00000001, {1'b1, 32'h00000000}};
    dir[5] = '{32'h7FFFFFFF, 32'h00000001, {1'b0, 32'h80000000}};
    dir[6] = '{32'h00000000, 32'h00000000, {1'b0, 32'h00000000}};
    dir[7] = '{32'h12345678, 32'h00000000, {1'b0, 32'h12345678}};
    for (int i = 0; i < 8; i++)
      add_chk($sformatf("dir%0d", i), dir[i].a, dir[i].b, dir[i].e);

    // Asynchronous reset mid-stream while the result is nonzero.
    add_chk("pre_rst", 32'h11111111, 32'h22222222, {1'b0, 32'h33333333});
    @(negedge clk);
    a_s = 32'hF0000000;
    b_s = 32'h20000005;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 33'h0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 33'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("rst_release", {1'b1, 32'h10000005});

    for (int n = 0; n < NRAND; n++) begin
      ra = $urandom;
      rb = $urandom;
      // Every fourth pair is biased toward long carry chains.
      if ((n % 4) == 3) rb = ~ra ^ (32'h1 << $urandom_range(0, 31));
      add_chk("rand", ra, rb, model(ra, rb));
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
